// File: rtl/bus_sram_target_if.sv
// Burst bus between a DMA master and the SRAM responder.
// The master drives the *In signals, the responder drives the *Out signals.
interface bus_sram_target_if;
   logic        beginTransactionIn;
   logic        readNotWriteIn;
   logic [3:0]  byteEnablesIn;
   logic [7:0]  burstSizeIn;
   logic [31:0] addressDataIn;
   logic        dataValidIn;
   logic        endTransactionIn;
   logic [31:0] addressDataOut;
   logic        dataValidOut;
   logic        endTransactionOut;
   logic        busErrorOut;
   logic        busyOut;

   modport slave (
      input  beginTransactionIn, readNotWriteIn, byteEnablesIn, burstSizeIn,
             addressDataIn, dataValidIn, endTransactionIn,
      output addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
   );

   modport master (
      output beginTransactionIn, readNotWriteIn, byteEnablesIn, burstSizeIn,
             addressDataIn, dataValidIn, endTransactionIn,
      input  addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut
   );
endinterface

// File: rtl/bus_sram_target.sv
// Burst-bus responder mapping a byte-maskable single-port SRAM into a fixed
// address window, with window/alignment errors and optional write stalls.
module bus_sram_target #(
   parameter logic [31:0] baseAddress   = 32'h5000_0000,
   parameter int          nrOfWords     = 512,
   parameter int          stallInterval = 0
) (
   input  logic               clock,
   input  logic               reset,
   bus_sram_target_if.slave   bus
);
   localparam int IDX_W   = $clog2(nrOfWords);
   localparam int STALL_W = (stallInterval > 1) ? $clog2(stallInterval + 1) : 1;

   typedef enum logic [2:0] {
      IDLE, READ, READ_END, WRITE, ERROR_READ, ERROR_WRITE
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt, ram_addr, begin_idx;
   logic [8:0]         cnt, cnt_nxt;
   logic [3:0]         be, be_nxt;
   logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
   logic [31:0]        addr_off;
   logic               req_err, rd_issue, ram_we;
   logic               err_nxt, end_nxt, busy_nxt;

   logic [31:0]        mem [nrOfWords];
   logic [31:0]        ram_q_p1;
   logic               rd_vld_p1;
   logic [31:0]        data_p2;
   logic               vld_p2;
   logic               end_q, err_q, busy_q;

   // The 33-bit span keeps a burst near the top of the address space from wrapping into the window.
   function automatic logic window_error(input logic [31:0] addr, input logic [31:0] off,
                                         input logic [7:0] burst, input logic [3:0] lanes);
      logic [32:0] span;
      span = {3'b000, off[31:2]} + {25'd0, burst} + 33'd1;
      return (off[1:0] != 2'b00) || (addr < baseAddress) ||
             (span > 33'(nrOfWords)) || (lanes == 4'h0);
   endfunction

   assign addr_off  = bus.addressDataIn - baseAddress;
   assign begin_idx = addr_off[IDX_W+1:2];
   assign req_err   = window_error(bus.addressDataIn, addr_off, bus.burstSizeIn, bus.byteEnablesIn);

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      cnt_nxt       = cnt;
      be_nxt        = be;
      stall_cnt_nxt = stall_cnt;
      ram_addr      = idx;
      ram_we        = 1'b0;
      rd_issue      = 1'b0;
      err_nxt       = 1'b0;
      end_nxt       = 1'b0;
      busy_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.beginTransactionIn) begin
               be_nxt        = bus.byteEnablesIn;
               stall_cnt_nxt = '0;
               if (req_err) begin
                  err_nxt   = 1'b1;
                  state_nxt = bus.readNotWriteIn ? ERROR_READ : ERROR_WRITE;
               end else if (bus.readNotWriteIn) begin
                  // First word is fetched in the begin cycle to meet the 2-cycle read latency.
                  ram_addr  = begin_idx;
                  rd_issue  = 1'b1;
                  idx_nxt   = begin_idx + 1'b1;
                  cnt_nxt   = {1'b0, bus.burstSizeIn};
                  state_nxt = READ;
               end else begin
                  idx_nxt   = begin_idx;
                  cnt_nxt   = {1'b0, bus.burstSizeIn} + 9'd1;
                  state_nxt = WRITE;
               end
            end
         end
         READ: begin
            if (cnt != 9'd0) begin
               rd_issue = 1'b1;
               idx_nxt  = idx + 1'b1;
               cnt_nxt  = cnt - 9'd1;
            end else begin
               state_nxt = READ_END;
            end
         end
         READ_END: begin
            end_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         WRITE: begin
            if (bus.dataValidIn && !busy_q && cnt != 9'd0) begin
               ram_we  = 1'b1;
               idx_nxt = idx + 1'b1;
               cnt_nxt = cnt - 9'd1;
               if (stallInterval != 0) begin
                  if (stall_cnt == STALL_W'(stallInterval - 1)) begin
                     stall_cnt_nxt = '0;
                     busy_nxt      = !bus.endTransactionIn;
                  end else begin
                     stall_cnt_nxt = stall_cnt + 1'b1;
                  end
               end
            end
            if (bus.endTransactionIn) state_nxt = IDLE;
         end
         ERROR_READ: begin
            end_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         ERROR_WRITE: begin
            if (bus.endTransactionIn) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         be        <= '0;
         stall_cnt <= '0;
         err_q     <= 1'b0;
         end_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         cnt       <= cnt_nxt;
         be        <= be_nxt;
         stall_cnt <= stall_cnt_nxt;
         err_q     <= err_nxt;
         end_q     <= end_nxt;
         busy_q    <= busy_nxt;
      end
   end

   // p1: synchronous SRAM access
   always_ff @(posedge clock) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[ram_addr][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
         end
      end
      ram_q_p1 <= mem[ram_addr];
   end

   // p2: registered read-data outputs, data forced to zero when not valid
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_vld_p1 <= 1'b0;
         vld_p2    <= 1'b0;
         data_p2   <= '0;
      end else begin
         rd_vld_p1 <= rd_issue;
         vld_p2    <= rd_vld_p1;
         data_p2   <= rd_vld_p1 ? ram_q_p1 : 32'd0;
      end
   end

   assign bus.addressDataOut    = data_p2;
   assign bus.dataValidOut      = vld_p2;
   assign bus.endTransactionOut = end_q;
   assign bus.busErrorOut       = err_q;
   assign bus.busyOut           = busy_q;
endmodule

// File: tb/tb_bus_sram_target.sv
// Randomized bench for bus_sram_target against an array-based memory model
// derived directly from the bus protocol rules.
module tb_bus_sram_target;
   localparam logic [31:0] BASE  = 32'h5000_0000;
   localparam int          WORDS = 512;
   localparam int          STALL = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   bus_sram_target_if bus();

   bus_sram_target #(.baseAddress(BASE), .nrOfWords(WORDS), .stallInterval(STALL)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] ref_mem [WORDS];
   logic [31:0] wd [300];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit req_bad(input logic [31:0] addr, input int burst, input logic [3:0] be);
      longint off;
      off = longint'(addr) - longint'(BASE);
      return (addr[1:0] != 2'b00) || (off < 0) || (off / 4 + burst + 1 > WORDS) || (be == 4'h0);
   endfunction

   task automatic idle_inputs();
      bus.beginTransactionIn = 1'b0;
      bus.readNotWriteIn     = 1'b0;
      bus.byteEnablesIn      = 4'h0;
      bus.burstSizeIn        = 8'h0;
      bus.addressDataIn      = 32'h0;
      bus.dataValidIn        = 1'b0;
      bus.endTransactionIn   = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int burst, input logic [3:0] be,
                          input int abort_at);
      bit e;
      int bidx;
      e = req_bad(addr, burst, be);
      bidx = int'((addr - BASE) >> 2);
      @(negedge clock);
      bus.beginTransactionIn = 1'b1;
      bus.readNotWriteIn     = 1'b1;
      bus.byteEnablesIn      = be;
      bus.burstSizeIn        = 8'(burst);
      bus.addressDataIn      = addr;
      @(negedge clock);
      bus.beginTransactionIn = 1'b0;
      bus.addressDataIn      = $urandom;
      chk("rd_err", bus.busErrorOut, e);
      chk("rd_vld_lat", bus.dataValidOut, 0);
      chk("rd_data_idle", bus.addressDataOut, 0);
      if (e) begin
         @(negedge clock);
         chk("rderr_end", bus.endTransactionOut, 1);
         chk("rderr_vld", bus.dataValidOut, 0);
         chk("rderr_err_once", bus.busErrorOut, 0);
      end else begin
         for (int i = 0; i <= burst; i++) begin
            @(negedge clock);
            chk("rd_vld", bus.dataValidOut, 1);
            chk("rd_data", bus.addressDataOut, ref_mem[bidx + i]);
            chk("rd_end_early", bus.endTransactionOut, 0);
            if (i == abort_at) begin
               reset = 1'b0;
               #1;
               chk("abort_data", bus.addressDataOut, 0);
               chk("abort_vld", bus.dataValidOut, 0);
               chk("abort_end", bus.endTransactionOut, 0);
               chk("abort_err", bus.busErrorOut, 0);
               chk("abort_busy", bus.busyOut, 0);
               @(negedge clock);
               reset = 1'b1;
               return;
            end
         end
         @(negedge clock);
         chk("rd_end", bus.endTransactionOut, 1);
         chk("rd_vld_after", bus.dataValidOut, 0);
         chk("rd_data_after", bus.addressDataOut, 0);
      end
   endtask

   // Words come from wd[]; the master re-presents a word whenever busyOut is high.
   task automatic do_write(input logic [31:0] addr, input int burst, input logic [3:0] be,
                           input int nsend);
      bit   e, prev_acc, b, exp_busy;
      int   acc, bidx, i;
      e = req_bad(addr, burst, be);
      bidx = int'((addr - BASE) >> 2);
      acc = 0;
      prev_acc = 1'b0;
      @(negedge clock);
      bus.beginTransactionIn = 1'b1;
      bus.readNotWriteIn     = 1'b0;
      bus.byteEnablesIn      = be;
      bus.burstSizeIn        = 8'(burst);
      bus.addressDataIn      = addr;
      @(negedge clock);
      bus.beginTransactionIn = 1'b0;
      chk("wr_err", bus.busErrorOut, e);
      i = 0;
      while (i < nsend) begin
         bus.dataValidIn   = 1'b1;
         bus.addressDataIn = wd[i];
         exp_busy = !e && prev_acc && (acc % STALL == 0);
         chk("wr_busy", bus.busyOut, exp_busy);
         b = bus.busyOut;
         prev_acc = 1'b0;
         if (!b) begin
            if (!e && acc <= burst) begin
               for (int k = 0; k < 4; k++)
                  if (be[k]) ref_mem[bidx + acc][8*k +: 8] = wd[i][8*k +: 8];
               acc++;
               prev_acc = 1'b1;
            end
            i++;
         end
         @(negedge clock);
      end
      bus.dataValidIn      = 1'b0;
      bus.endTransactionIn = 1'b1;
      exp_busy = !e && prev_acc && (acc % STALL == 0);
      chk("wr_busy_end", bus.busyOut, exp_busy);
      @(negedge clock);
      bus.endTransactionIn = 1'b0;
      chk("wr_busy_idle", bus.busyOut, 0);
      chk("wr_err_idle", bus.busErrorOut, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] addr;
      logic [3:0]  be;
      int          burst, sel;

      idle_inputs();
      repeat (3) @(negedge clock);
      chk("rst_data", bus.addressDataOut, 0);
      chk("rst_vld", bus.dataValidOut, 0);
      chk("rst_end", bus.endTransactionOut, 0);
      chk("rst_err", bus.busErrorOut, 0);
      chk("rst_busy", bus.busyOut, 0);
      reset = 1'b1;

      // Fill the whole SRAM so every later read has a defined model value.
      for (int h = 0; h < 2; h++) begin
         for (int k = 0; k < 256; k++) wd[k] = $urandom;
         do_write(BASE + 32'(h * 1024), 255, 4'hF, 256);
      end

      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
      do_write(32'h5000_0010, 3, 4'hF, 4);
      do_read(32'h5000_0010, 3, 4'hF, -1);

      wd[0] = 32'hAABB_CCDD;
      do_write(32'h5000_0000, 0, 4'hF, 1);
      wd[0] = 32'h1122_3344;
      do_write(32'h5000_0000, 0, 4'b0101, 1);
      do_read(32'h5000_0000, 0, 4'hF, -1);

      do_read(32'h5000_0800, 0, 4'hF, -1);
      do_read(32'h5000_07FC, 1, 4'hF, -1);
      do_read(32'h5000_0002, 0, 4'hF, -1);
      do_read(32'hFFFF_FFFC, 255, 4'hF, -1);
      do_read(32'h5000_0000, 0, 4'h0, -1);

      for (int k = 0; k < 4; k++) wd[k] = 32'hDEAD_0000 + 32'(k);
      do_write(32'h4FFF_FFFC, 3, 4'hF, 4);
      do_write(32'h5000_0000, 0, 4'h0, 2);
      do_read(32'h5000_0000, 0, 4'hF, -1);

      for (int k = 0; k < 6; k++) wd[k] = 32'hC0DE_0000 + 32'(k);
      do_write(32'h5000_0100, 5, 4'hF, 6);
      do_read(32'h5000_0100, 5, 4'hF, -1);

      for (int k = 0; k < 4; k++) wd[k] = 32'hE000_0000 + 32'(k);
      do_write(32'h5000_0200, 1, 4'hF, 4);
      do_read(32'h5000_0200, 3, 4'hF, -1);

      do_read(32'h5000_0040, 7, 4'hF, 2);
      do_read(32'h5000_0040, 7, 4'hF, -1);

      for (int t = 0; t < 60; t++) begin
         sel   = $urandom_range(0, 9);
         burst = $urandom_range(0, 15);
         be    = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         case (sel)
            0:       addr = BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(1, 3));
            1:       addr = BASE - 32'($urandom_range(1, 64) * 4);
            2:       addr = BASE + 32'((WORDS - $urandom_range(1, 8)) * 4);
            default: addr = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
         endcase
         if ($urandom_range(0, 1) == 1) begin
            do_read(addr, burst, be, -1);
         end else begin
            for (int k = 0; k < burst + 3; k++) wd[k] = $urandom;
            do_write(addr, burst, be, $urandom_range(1, burst + 3));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
